// File: rtl/bailey_border_ctrl.sv
// Border controller for a 7x7 Bailey-style window: sequences raster pixels into
// the row buffers, flushes the pipeline at frame end and drives border mux selects.
module bailey_border_ctrl #(
  parameter int ROW_WIDTH  = 100,
  parameter int COL_HEIGHT = 100,
  parameter int PIX_BIT    = 8,
  parameter int MASK_WIDTH = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PIX_BIT-1:0] in_pix,
  input  logic               in_valid,
  input  logic               in_sof,
  output logic               in_ready,
  input  logic               hold,
  output logic [PIX_BIT-1:0] data_cu2bufcf,
  output logic               ctrl2buf_valid,
  output logic               sel_top_row,
  output logic [1:0]         sel_btm_row,
  output logic               sel_left_col,
  output logic [1:0]         sel_right_col,
  output logic               win_valid,
  output logic               frame_done
);

  localparam int HALF        = MASK_WIDTH / 2;
  localparam int NPIX        = ROW_WIDTH * COL_HEIGHT;
  localparam int FLUSH_BEATS = HALF * ROW_WIDTH + HALF;
  localparam int TOTAL       = NPIX + FLUSH_BEATS;
  localparam int B_W         = $clog2(TOTAL);
  localparam int CR_W        = $clog2(COL_HEIGHT);
  localparam int CC_W        = $clog2(ROW_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [B_W-1:0]     b_q;
  logic [CR_W-1:0]    cr_q;
  logic [CC_W-1:0]    cc_q;
  logic [PIX_BIT-1:0] data_q;
  logic               vld_q, top_q, left_q, win_q, done_q;
  logic [1:0]         btm_q, right_q;

  logic               beat;
  logic [PIX_BIT-1:0] beat_pix;
  logic               last_pix, last_beat, in_win;
  logic               top_d, left_d;
  logic [1:0]         btm_d, right_d;
  logic [CR_W-1:0]    btm_diff;
  logic [CC_W-1:0]    right_diff;

  assign last_pix  = (b_q == B_W'(NPIX - 1));
  assign last_beat = (b_q == B_W'(TOTAL - 1));
  assign in_win    = (b_q >= B_W'(FLUSH_BEATS));

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (beat) state_d = S_RUN;
      S_RUN:   if (beat && last_pix) state_d = S_FLUSH;
      S_FLUSH: if (beat && last_beat) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Only an in_sof beat opens a frame; once running, in_sof is plain data.
  always_comb begin
    in_ready = 1'b0;
    beat     = 1'b0;
    beat_pix = '0;
    case (state_q)
      S_IDLE: begin
        in_ready = reset & ~hold;
        beat     = in_valid & in_ready & in_sof;
        beat_pix = in_pix;
      end
      S_RUN: begin
        in_ready = reset & ~hold;
        beat     = in_valid & in_ready;
        beat_pix = in_pix;
      end
      S_FLUSH: beat = reset & ~hold;
      default: ;
    endcase
  end

  // Border selects for the window centred at (cr_q, cc_q); zero while priming.
  always_comb begin
    btm_diff   = cr_q - CR_W'(COL_HEIGHT - HALF - 1);
    right_diff = cc_q - CC_W'(ROW_WIDTH - HALF - 1);
    top_d      = in_win && (cr_q < CR_W'(HALF));
    left_d     = in_win && (cc_q < CC_W'(HALF));
    btm_d      = (in_win && cr_q >= CR_W'(COL_HEIGHT - HALF)) ? btm_diff[1:0] : 2'd0;
    right_d    = (in_win && cc_q >= CC_W'(ROW_WIDTH - HALF)) ? right_diff[1:0] : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      b_q     <= '0;
      cr_q    <= '0;
      cc_q    <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      top_q   <= 1'b0;
      left_q  <= 1'b0;
      btm_q   <= 2'd0;
      right_q <= 2'd0;
      win_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      vld_q  <= beat;
      done_q <= (state_q == S_DONE);
      if (beat) begin
        data_q  <= beat_pix;
        win_q   <= in_win;
        top_q   <= top_d;
        left_q  <= left_d;
        btm_q   <= btm_d;
        right_q <= right_d;
        b_q     <= last_beat ? '0 : b_q + 1'b1;
        // Counters return to zero on the final beat, ready for the next frame.
        if (in_win) begin
          if (cc_q == CC_W'(ROW_WIDTH - 1)) begin
            cc_q <= '0;
            cr_q <= (cr_q == CR_W'(COL_HEIGHT - 1)) ? '0 : cr_q + 1'b1;
          end else begin
            cc_q <= cc_q + 1'b1;
          end
        end
      end
    end
  end

  assign data_cu2bufcf  = data_q;
  assign ctrl2buf_valid = vld_q;
  assign sel_top_row    = top_q;
  assign sel_btm_row    = btm_q;
  assign sel_left_col   = left_q;
  assign sel_right_col  = right_q;
  assign win_valid      = win_q;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_bailey_border_ctrl.sv
// Scoreboard bench for bailey_border_ctrl on an 8x6 frame (27 flush beats).
module tb_bailey_border_ctrl;
  localparam int RW = 8;
  localparam int CH = 6;
  localparam int F  = 3 * RW + 3;
  localparam int NP = RW * CH;
  localparam int TB = NP + F;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_pix = '0;
  logic       in_valid = 1'b0, in_sof = 1'b0, hold = 1'b0;
  logic       in_ready, ctrl2buf_valid, sel_top_row, sel_left_col, win_valid, frame_done;
  logic [1:0] sel_btm_row, sel_right_col;
  logic [7:0] data_cu2bufcf;

  typedef struct packed {
    logic [7:0] data;
    logic       win;
    logic       top;
    logic [1:0] btm;
    logic       left;
    logic [1:0] right;
  } beat_t;

  beat_t sb_q[$];
  beat_t obs[TB];
  int    n_checks = 0;
  int    n_pass = 0;

  bailey_border_ctrl #(.ROW_WIDTH(RW), .COL_HEIGHT(CH), .PIX_BIT(8), .MASK_WIDTH(7)) dut (
    .clk(clk), .reset(reset), .in_pix(in_pix), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .hold(hold), .data_cu2bufcf(data_cu2bufcf),
    .ctrl2buf_valid(ctrl2buf_valid), .sel_top_row(sel_top_row), .sel_btm_row(sel_btm_row),
    .sel_left_col(sel_left_col), .sel_right_col(sel_right_col), .win_valid(win_valid),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic beat_t model(input int b, input logic [7:0] pix);
    beat_t e;
    int w, cr, cc;
    e = '0;
    if (b < NP) e.data = pix;
    if (b >= F) begin
      w  = b - F;
      cr = w / RW;
      cc = w % RW;
      e.win   = 1'b1;
      e.top   = (cr <= 2);
      e.btm   = (cr >= CH - 3) ? 2'(cr - (CH - 4)) : 2'd0;
      e.left  = (cc <= 2);
      e.right = (cc >= RW - 3) ? 2'(cc - (RW - 4)) : 2'd0;
    end
    return e;
  endfunction

  // Drives one frame with random gaps/stalls; checks every cycle against the scoreboard.
  task automatic run_frame(input string tag, input int gap_pct, input int hold_pct,
                           input int pre_junk, input int mid_sof_at, input int rst_at,
                           input logic [7:0] seed, output bit aborted);
    int bi, nobs, wins, cyc;
    beat_t got, exp;
    bit h, v, bt, exp_rdy;
    bi = 0; nobs = 0; wins = 0; cyc = 0;
    aborted = 1'b0;
    sb_q.delete();
    for (int j = 0; j < pre_junk; j++) begin
      in_valid = 1'b1; in_sof = 1'b0; hold = 1'b0; in_pix = 8'(8'hE0 + j);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL %s junk_ready: got %b want 1", tag, in_ready);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (ctrl2buf_valid !== 1'b0) $display("FAIL %s junk_beat: got %b want 0", tag, ctrl2buf_valid);
      else n_pass++;
    end
    while (bi < TB) begin
      cyc++;
      if (cyc > 4000) begin
        n_checks++;
        $display("FAIL %s timeout: got %0d beats want %0d", tag, bi, TB);
        break;
      end
      h = ($urandom_range(99, 0) < hold_pct);
      v = (bi >= NP) ? 1'($urandom_range(1, 0)) : !($urandom_range(99, 0) < gap_pct);
      hold = h; in_valid = v;
      in_sof = (bi == 0) || (bi == mid_sof_at);
      in_pix = 8'(seed + bi * 5);
      if (bi == rst_at) begin
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL %s rst_ready: got %b want 0", tag, in_ready);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({data_cu2bufcf, ctrl2buf_valid, sel_top_row, sel_btm_row, sel_left_col,
             sel_right_col, win_valid, frame_done} !== 16'h0)
          $display("FAIL %s rst_outputs: got %h want 0", tag, {data_cu2bufcf, ctrl2buf_valid,
                   sel_top_row, sel_btm_row, sel_left_col, sel_right_col, win_valid, frame_done});
        else n_pass++;
        reset = 1'b1; hold = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        aborted = 1'b1;
        return;
      end
      #1;
      exp_rdy = (bi < NP) ? !h : 1'b0;
      n_checks++;
      if (in_ready !== exp_rdy) $display("FAIL %s ready b%0d: got %b want %b", tag, bi, in_ready, exp_rdy);
      else n_pass++;
      bt = (bi < NP) ? (v && !h) : !h;
      if (bt) begin
        sb_q.push_back(model(bi, in_pix));
        bi++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (ctrl2buf_valid !== bt) $display("FAIL %s beat_flag b%0d: got %b want %b", tag, bi, ctrl2buf_valid, bt);
      else n_pass++;
      if (ctrl2buf_valid === 1'b1) begin
        got = {data_cu2bufcf, win_valid, sel_top_row, sel_btm_row, sel_left_col, sel_right_col};
        n_checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL %s extra_beat: got beat %h want none", tag, got);
        end else begin
          exp = sb_q.pop_front();
          if (got !== exp) $display("FAIL %s beat%0d: got %h want %h", tag, nobs, got, exp);
          else n_pass++;
        end
        if (nobs < TB) obs[nobs] = got;
        if (win_valid === 1'b1) wins++;
        nobs++;
      end
    end
    hold = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    n_checks++;
    if (frame_done !== 1'b0) $display("FAIL %s done_early: got %b want 0", tag, frame_done);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({frame_done, ctrl2buf_valid} !== 2'b10)
      $display("FAIL %s done_pulse: got %b want 10", tag, {frame_done, ctrl2buf_valid});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({frame_done, in_ready} !== 2'b01)
      $display("FAIL %s done_idle: got %b want 01", tag, {frame_done, in_ready});
    else n_pass++;
    n_checks++;
    if (wins !== NP || nobs !== TB) $display("FAIL %s counts: got %0d/%0d want %0d/%0d", tag, wins, nobs, NP, TB);
    else n_pass++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      reset = 1'b0; in_valid = 1'b1; in_sof = 1'b1; hold = 1'b0; in_pix = 8'h5A;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", in_ready);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if ({data_cu2bufcf, ctrl2buf_valid, sel_top_row, sel_btm_row, sel_left_col,
           sel_right_col, win_valid, frame_done} !== 16'h0)
        $display("FAIL reset_outputs: got %h want 0", {data_cu2bufcf, ctrl2buf_valid,
                 sel_top_row, sel_btm_row, sel_left_col, sel_right_col, win_valid, frame_done});
      else n_pass++;
    end
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_full_frame();
    bit ab;
    beat_t e26, e27, e74;
    run_frame("full", 0, 0, 0, -1, -1, 8'h10, ab);
    e26 = {8'h92, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
    e27 = {8'h97, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0};
    e74 = {8'h00, 1'b1, 1'b0, 2'd3, 1'b0, 2'd3};
    n_checks++;
    if (obs[26] !== e26) $display("FAIL full_beat26: got %h want %h", obs[26], e26);
    else n_pass++;
    n_checks++;
    if (obs[27] !== e27) $display("FAIL full_beat27: got %h want %h", obs[27], e27);
    else n_pass++;
    n_checks++;
    if (obs[74] !== e74) $display("FAIL full_beat74: got %h want %h", obs[74], e74);
    else n_pass++;
  endtask

  task automatic test_stalls();
    bit ab;
    run_frame("stall", 30, 25, 0, -1, -1, 8'h33, ab);
  endtask

  task automatic test_junk_before_sof();
    bit ab;
    run_frame("junk", 0, 0, 3, -1, -1, 8'h50, ab);
  endtask

  task automatic test_mid_sof();
    bit ab;
    run_frame("midsof", 10, 10, 0, 20, -1, 8'h71, ab);
  endtask

  task automatic test_reset_mid();
    bit ab;
    run_frame("rstmid", 0, 0, 0, -1, 40, 8'h88, ab);
    n_checks++;
    if (ab !== 1'b1) $display("FAIL rstmid_abort: got %b want 1", ab);
    else n_pass++;
    run_frame("after_rst", 0, 0, 2, -1, -1, 8'hA0, ab);
  endtask

  task automatic test_back_to_back();
    bit ab;
    run_frame("b2b_a", 20, 20, 0, -1, -1, 8'hC3, ab);
    run_frame("b2b_b", 15, 30, 0, -1, -1, 8'h07, ab);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stalls();
    test_junk_before_sof();
    test_mid_sof();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
